// File: rtl/dice_turn_scheduler_if.sv
// rtl/dice_turn_scheduler_if.sv - player/dice side signal bundle for dice_turn_scheduler
interface dice_turn_scheduler_if #(
   parameter int N_PLAYERS = 4,
   parameter int SCORE_W   = 8
);
   localparam int TW = $clog2(N_PLAYERS);

   logic [N_PLAYERS-1:0]         req;
   logic [N_PLAYERS-1:0]         player_en;
   logic                         new_game;
   logic [2:0]                   throw;
   logic                         dice_button;
   logic [N_PLAYERS-1:0]         grant;
   logic [TW-1:0]                turn;
   logic [2:0]                   result;
   logic                         result_valid;
   logic                         bad_throw;
   logic [N_PLAYERS*SCORE_W-1:0] score;
   logic                         game_over;
   logic [TW-1:0]                winner;

   modport master (
      output req, player_en, new_game, throw,
      input  dice_button, grant, turn, result, result_valid, bad_throw, score, game_over, winner
   );

   modport slave (
      input  req, player_en, new_game, throw,
      output dice_button, grant, turn, result, result_valid, bad_throw, score, game_over, winner
   );
endinterface

// File: rtl/dice_turn_scheduler.sv
// rtl/dice_turn_scheduler.sv - round-robin dice turn scheduler with per-player scoring
// Optional same-player reroll on a six: define DICE_SIX_REROLL_EN.
module dice_turn_scheduler #(
   parameter int N_PLAYERS    = 4,
   parameter int SCORE_W      = 8,
   parameter int TARGET       = 20,
   parameter int MIN_ROLL_CYC = 4,
   parameter int SETTLE_CYC   = 2
) (
   input logic                   clk,
   input logic                   rst,
   dice_turn_scheduler_if.slave  bus
);
   localparam int TW   = $clog2(N_PLAYERS);
   localparam int RC_W = $clog2(MIN_ROLL_CYC + 1);
   localparam int SC_W = $clog2(SETTLE_CYC + 1);
   localparam logic [RC_W-1:0]    ROLL_MAX   = RC_W'(MIN_ROLL_CYC);
   localparam logic [SC_W-1:0]    SETTLE_MAX = SC_W'(SETTLE_CYC);
   localparam logic [SCORE_W-1:0] TARGET_V   = SCORE_W'(TARGET);

   typedef enum logic [2:0] {S_IDLE, S_ROLL, S_SETTLE, S_SCORE, S_DONE} state_t;

   state_t                       r_state;
   logic [TW-1:0]                r_turn;
   logic [N_PLAYERS*SCORE_W-1:0] r_score;
   logic [RC_W-1:0]              r_roll_cnt;
   logic [SC_W-1:0]              r_settle_cnt;
   logic                         r_dice_button;
   logic [N_PLAYERS-1:0]         r_grant;
   logic [2:0]                   r_result;
   logic                         r_result_valid;
   logic                         r_bad_throw;
   logic                         r_game_over;
   logic [TW-1:0]                r_winner;

   logic [SCORE_W-1:0] w_cur_score;
   logic [SCORE_W:0]   w_sum;
   logic [SCORE_W-1:0] w_new_score;
   logic               w_throw_ok;
   logic               w_win;
   logic               w_keep;
   logic [TW-1:0]      w_next_turn;
   logic [TW-1:0]      w_score_turn;
   logic [TW-1:0]      w_lowest;

   function automatic logic [N_PLAYERS-1:0] f_onehot(input logic [TW-1:0] t);
      return {{(N_PLAYERS-1){1'b0}}, 1'b1} << t;
   endfunction

   // First enabled index after cur, wrapping; cur itself when nobody else is enabled.
   function automatic logic [TW-1:0] f_next(input logic [TW-1:0] cur, input logic [N_PLAYERS-1:0] en);
      logic [TW-1:0] res;
      logic [TW-1:0] idx;
      logic          found;
      res   = cur;
      found = 1'b0;
      for (int k = 1; k < N_PLAYERS; k++) begin
         idx = TW'((int'(cur) + k) % N_PLAYERS);
         if (!found && en[idx]) begin
            res   = idx;
            found = 1'b1;
         end
      end
      return res;
   endfunction

   function automatic logic [TW-1:0] f_lowest(input logic [N_PLAYERS-1:0] en);
      logic [TW-1:0] res;
      res = '0;
      for (int i = N_PLAYERS - 1; i >= 0; i--) begin
         if (en[TW'(i)]) res = TW'(i);
      end
      return res;
   endfunction

   assign w_cur_score  = r_score[r_turn*SCORE_W +: SCORE_W];
   assign w_throw_ok   = (bus.throw != 3'd0) && (bus.throw != 3'd7);
   assign w_sum        = {1'b0, w_cur_score} + (SCORE_W+1)'(bus.throw);
   assign w_new_score  = !w_throw_ok ? w_cur_score :
                         (w_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0]);
   assign w_win        = (w_new_score >= TARGET_V);
   assign w_next_turn  = f_next(r_turn, bus.player_en);
   assign w_lowest     = f_lowest(bus.player_en);
   assign w_score_turn = w_keep ? r_turn : w_next_turn;

`ifdef DICE_SIX_REROLL_EN
   logic [1:0] r_reroll_cnt;

   // At most two bonus rolls in a row; any advancing turn clears the streak.
   assign w_keep = w_throw_ok && (bus.throw == 3'd6) && (r_reroll_cnt < 2'd2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_reroll_cnt <= 2'd0;
      end else if (bus.new_game) begin
         r_reroll_cnt <= 2'd0;
      end else if (r_state == S_SCORE && !w_win) begin
         r_reroll_cnt <= w_keep ? r_reroll_cnt + 2'd1 : 2'd0;
      end
   end
`else
   assign w_keep = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_turn         <= '0;
         r_score        <= '0;
         r_roll_cnt     <= '0;
         r_settle_cnt   <= '0;
         r_dice_button  <= 1'b0;
         r_grant        <= N_PLAYERS'(bus.player_en[0]);
         r_result       <= 3'd0;
         r_result_valid <= 1'b0;
         r_bad_throw    <= 1'b0;
         r_game_over    <= 1'b0;
         r_winner       <= '0;
      end else begin
         r_result_valid <= 1'b0;
         r_bad_throw    <= 1'b0;
         if (bus.new_game) begin
            r_state       <= S_IDLE;
            r_score       <= '0;
            r_game_over   <= 1'b0;
            r_dice_button <= 1'b0;
            r_roll_cnt    <= '0;
            r_settle_cnt  <= '0;
            r_turn        <= w_lowest;
            r_grant       <= bus.player_en[w_lowest] ? f_onehot(w_lowest) : '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (bus.player_en[r_turn]) begin
                     r_grant <= f_onehot(r_turn);
                     if (bus.req[r_turn]) begin
                        r_state       <= S_ROLL;
                        r_dice_button <= 1'b1;
                        r_roll_cnt    <= RC_W'(1);
                     end
                  end else begin
                     r_turn  <= w_next_turn;
                     r_grant <= bus.player_en[w_next_turn] ? f_onehot(w_next_turn) : '0;
                  end
               end
               S_ROLL: begin
                  // The roll belongs to r_turn even if its enable drops mid-roll.
                  r_grant <= f_onehot(r_turn);
                  if (r_roll_cnt >= ROLL_MAX && !bus.req[r_turn]) begin
                     r_state       <= S_SETTLE;
                     r_dice_button <= 1'b0;
                     r_settle_cnt  <= SC_W'(1);
                  end else if (r_roll_cnt < ROLL_MAX) begin
                     r_roll_cnt <= r_roll_cnt + RC_W'(1);
                  end
               end
               S_SETTLE: begin
                  r_grant <= f_onehot(r_turn);
                  if (r_settle_cnt >= SETTLE_MAX) r_state <= S_SCORE;
                  else                            r_settle_cnt <= r_settle_cnt + SC_W'(1);
               end
               S_SCORE: begin
                  r_result       <= bus.throw;
                  r_result_valid <= 1'b1;
                  r_bad_throw    <= !w_throw_ok;
                  r_score[r_turn*SCORE_W +: SCORE_W] <= w_new_score;
                  if (w_win) begin
                     r_state     <= S_DONE;
                     r_winner    <= r_turn;
                     r_game_over <= 1'b1;
                     r_grant     <= '0;
                  end else begin
                     r_state <= S_IDLE;
                     r_turn  <= w_score_turn;
                     r_grant <= bus.player_en[w_score_turn] ? f_onehot(w_score_turn) : '0;
                  end
               end
               S_DONE: begin
                  r_grant       <= '0;
                  r_dice_button <= 1'b0;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.dice_button  = r_dice_button;
   assign bus.grant        = r_grant;
   assign bus.turn         = r_turn;
   assign bus.result       = r_result;
   assign bus.result_valid = r_result_valid;
   assign bus.bad_throw    = r_bad_throw;
   assign bus.score        = r_score;
   assign bus.game_over    = r_game_over;
   assign bus.winner       = r_winner;
endmodule

// File: doc/dice_turn_scheduler.md
Name: dice_turn_scheduler

Overview:
- Shares the single electronic dice between N_PLAYERS players using round-robin turns.
- Owns the dice's roll input: it holds the roll asserted while the current player presses, enforces a minimum roll time and a settle window, then samples throw.
- Accumulates per-player scores and declares a winner when a score reaches TARGET.
- Sits between the player buttons and the dice block at the game top level.

Parameters:
- N_PLAYERS, 4, number of players (2..8).
- SCORE_W, 8, width of each player score.
- TARGET, 20, score at or above which the game ends.
- MIN_ROLL_CYC, 4, minimum cycles dice_button stays high per roll (>=1).
- SETTLE_CYC, 2, cycles with dice_button low before throw is sampled (>=1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_PLAYERS  per-player roll buttons, level, already synchronised.
- player_en  in  N_PLAYERS  participation mask; disabled players are skipped.
- new_game  in  1  one-cycle pulse; clears scores and restarts the game.
- throw  in  3  dice value from the dice block, legal range 1..6.
- dice_button  out  1  roll drive to the dice block.
- grant  out  N_PLAYERS  one-hot current player; zero in DONE.
- turn  out  clog2(N_PLAYERS)  index of current player.
- result  out  3  last sampled throw.
- result_valid  out  1  one-cycle pulse when result updates.
- bad_throw  out  1  one-cycle pulse, coincident with result_valid, when throw is 0 or 7.
- score  out  N_PLAYERS*SCORE_W  flattened scores; player i occupies [i*SCORE_W +: SCORE_W].
- game_over  out  1  high in DONE.
- winner  out  clog2(N_PLAYERS)  index of winning player, valid while game_over.

Behaviour:
- Reset (async): state IDLE, turn=0, all scores 0, dice_button=0, result=0, result_valid=0, bad_throw=0, game_over=0, winner=0. grant=one-hot(0) if player_en[0], else 0.
- All outputs are registered.
- IDLE:
  - If player_en[turn]=0, advance turn to the next enabled player (rule below), one hop per cycle.
  - If req[turn]=1 and player_en[turn]=1: go to ROLL and drive dice_button=1 from the next edge; roll_cnt=1.
  - req from non-current players is ignored.
- ROLL:
  - dice_button=1; roll_cnt increments each cycle, saturating.
  - Exit to SETTLE when roll_cnt>=MIN_ROLL_CYC and req[turn]=0. An early release still yields exactly MIN_ROLL_CYC high cycles.
- SETTLE: dice_button=0; count SETTLE_CYC cycles, then go to SCORE.
- SCORE (1 cycle):
  - Sample throw: result<=throw; pulse result_valid.
  - If throw is in 1..6, score[turn] += throw, saturating at 2^SCORE_W-1.
  - If throw is 0 or 7, pulse bad_throw and leave score unchanged.
  - If the new score >= TARGET: go to DONE, winner<=turn, game_over<=1.
  - Otherwise advance turn and go to IDLE.
- Turn advance: next enabled index after turn, wrapping modulo N_PLAYERS. If only turn itself is enabled, turn is unchanged. If no player is enabled, turn is unchanged and the block stays in IDLE with grant=0.
- DONE: dice_button=0, grant=0; hold scores and winner; req ignored.
- new_game (any state): next edge sets scores=0, game_over=0, dice_button=0, turn=lowest enabled index (0 if none), state IDLE. new_game takes priority over every other transition in the same cycle.
- player_en[turn] cleared during ROLL/SETTLE: the current roll completes and scores normally; the mask only affects turn selection.

Optional Feature:
- Macro: DICE_SIX_REROLL_EN.
- Defined: a valid throw of 6 that does not end the game keeps turn unchanged, so the same player rolls again. A maximum of 2 consecutive extra rolls per turn; after that the turn advances normally.
- Undefined: turn always advances after SCORE.

Test Plan:
- Reset mid-ROLL (dice_button=1) -> next sample: dice_button=0, turn=0, score all 0, state IDLE.
- player_en=4'b1111, req[0] held 10 cycles, throw=5 -> dice_button high 10 cycles, low 2; result=5, result_valid 1 cycle; score0=5; turn=1.
- req[1] pulsed 1 cycle with MIN_ROLL_CYC=4 -> dice_button high exactly 4 cycles; req[2] asserted meanwhile is ignored.
- player_en=4'b1010 starting at turn=1, throw=3 -> turn goes to 3, then wraps to 1; grant is never 4'b0001 or 4'b0100.
- throw=7 -> bad_throw and result_valid pulse together, result=7, score unchanged, turn advances.
- score2=18, throw=4 -> score2=22, game_over=1, winner=2, grant=0; new_game -> scores 0, game_over=0, turn=lowest enabled index.
